// File: rtl/mole_pkg.sv
// Shared types and constants for the mole scheduler: positions, level codes,
// FSM states, LFSR taps and per-level concurrency limit.
package mole_pkg;
  localparam int NUM_POS = 5;

  localparam logic [1:0] LVL_EASY = 2'd0;
  localparam logic [1:0] LVL_MED  = 2'd1;
  localparam logic [1:0] LVL_HARD = 2'd2;

  typedef enum logic [1:0] {IDLE, GAP, SPAWN} state_e;

  // Fibonacci taps 8,6,5,4 -> register bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [2:0] max_moles(input logic [1:0] lvl);
    case (lvl)
      LVL_EASY: return 3'd1;
      LVL_MED:  return 3'd2;
      default:  return 3'd3;
    endcase
  endfunction

  function automatic logic [2:0] popcnt5(input logic [NUM_POS-1:0] v);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < NUM_POS; i++) s = s + {2'b00, v[i]};
    return s;
  endfunction
endpackage

// File: rtl/mole_scheduler_if.sv
// Control/status bundle between game FSM, hit logic and the mole scheduler.
interface mole_scheduler_if;
  import mole_pkg::*;
  logic               enable;
  logic [1:0]         level;
  logic [NUM_POS-1:0] hit_req;
  logic [NUM_POS-1:0] mole_led;
  logic               hit_pulse;
  logic [2:0]         hit_count;
  logic               timeout_pulse;
  logic [2:0]         active_cnt;

  modport master (output enable, level, hit_req,
                  input  mole_led, hit_pulse, hit_count, timeout_pulse, active_cnt);
  modport slave  (input  enable, level, hit_req,
                  output mole_led, hit_pulse, hit_count, timeout_pulse, active_cnt);
endinterface

// File: rtl/mole_slot_timer.sv
// One LED position: lifetime load, per-tick decrement, expiry and hit clear.
module mole_slot_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_tick,
  input  logic       i_hit,
  input  logic       i_load,
  input  logic [8:0] i_life,
  output logic       o_lit,
  output logic       o_hit,
  output logic       o_exp
);
  logic       r_lit;
  logic [8:0] r_life;

  assign o_lit = r_lit;
  assign o_hit = r_lit & i_hit;
  // a hit landing on the final tick beats the expiry
  assign o_exp = r_lit & i_tick & ~i_hit & (r_life == 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lit  <= 1'b0;
      r_life <= '0;
    end else if (i_clr) begin
      r_lit  <= 1'b0;
      r_life <= '0;
    end else if (i_load) begin
      r_lit  <= 1'b1;
      r_life <= i_life;
    end else if (o_hit) begin
      r_lit  <= 1'b0;
      r_life <= '0;
    end else if (r_lit && i_tick) begin
      r_life <= r_life - 9'd1;
      if (r_life == 9'd1) r_lit <= 1'b0;
    end
  end
endmodule

// File: rtl/mole_scheduler.sv
// Mole scheduler top: tick prescaler, LFSR, spawn FSM and five slot timers.
// Optional MOLE_SPEEDUP_EN shortens loaded lifetimes as the player scores hits.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int         TICK_DIV  = 1_000_000,
  parameter int         LIFE_EASY = 300,
  parameter int         LIFE_MED  = 200,
  parameter int         LIFE_HARD = 100,
  parameter int         GAP_EASY  = 100,
  parameter int         GAP_MED   = 60,
  parameter int         GAP_HARD  = 30,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic              clk,
  input logic              rst_n,
  mole_scheduler_if.slave  bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (LIFE_EASY > 511 || LIFE_MED > 511 || LIFE_HARD > 511 ||
      GAP_EASY > 511 || GAP_MED > 511 || GAP_HARD > 511) begin : g_width_chk
    $error("mole_scheduler: lifetime/gap parameter exceeds 9-bit counter");
  end

  logic [PW-1:0]      r_pre;
  logic [7:0]         r_lfsr;
  state_e             r_state, w_state_nxt;
  logic [8:0]         r_gap, w_gap_nxt;
  logic               r_hit_pulse, r_to_pulse;
  logic [2:0]         r_hit_cnt;
  logic               w_tick;
  logic [8:0]         w_life_base, w_gap_val, w_life_load;
  logic [NUM_POS-1:0] w_lit, w_hit, w_exp, w_occ, w_load;
  logic [2:0]         w_start, w_idx;
  logic [3:0]         w_sum;
  logic               w_found;

  assign w_tick = bus.enable && (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_pre <= '0;
    else if (!bus.enable || w_tick) r_pre <= '0;
    else                            r_pre <= r_pre + 1'b1;
  end

  // free-running so spawn position depends on when the player starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
  end

  always_comb begin
    case (bus.level)
      LVL_EASY: begin w_life_base = 9'(LIFE_EASY); w_gap_val = 9'(GAP_EASY); end
      LVL_MED:  begin w_life_base = 9'(LIFE_MED);  w_gap_val = 9'(GAP_MED);  end
      default:  begin w_life_base = 9'(LIFE_HARD); w_gap_val = 9'(GAP_HARD); end
    endcase
  end

`ifdef MOLE_SPEEDUP_EN
  logic [3:0] r_acc, w_acc_sum;
  logic [1:0] r_speed;

  assign w_acc_sum   = r_acc + {1'b0, popcnt5(w_hit)};
  assign w_life_load = w_life_base - ({7'd0, r_speed} * (w_life_base >> 3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !bus.enable) begin
      r_acc   <= '0;
      r_speed <= '0;
    end else if (w_acc_sum >= 4'd8) begin
      r_acc   <= w_acc_sum - 4'd8;
      r_speed <= (r_speed == 2'd3) ? r_speed : r_speed + 2'd1;
    end else begin
      r_acc   <= w_acc_sum;
    end
  end
`else
  assign w_life_load = w_life_base;
`endif

  for (genvar g = 0; g < NUM_POS; g++) begin : g_slot
    mole_slot_timer u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (!bus.enable),
      .i_tick (w_tick),
      .i_hit  (bus.hit_req[g]),
      .i_load (w_load[g]),
      .i_life (w_life_load),
      .o_lit  (w_lit[g]),
      .o_hit  (w_hit[g]),
      .o_exp  (w_exp[g])
    );
  end

  // spawn sees the occupancy left after this cycle's hits and expiries
  assign w_occ   = w_lit & ~w_hit & ~w_exp;
  assign w_start = (r_lfsr[2:0] >= 3'd5) ? r_lfsr[2:0] - 3'd5 : r_lfsr[2:0];

  always_comb begin
    w_load  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    if (r_state == SPAWN && bus.enable && popcnt5(w_occ) < max_moles(bus.level)) begin
      for (int k = 0; k < NUM_POS; k++) begin
        w_sum = {1'b0, w_start} + 4'(k);
        w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
        if (!w_found && !w_occ[w_idx]) begin
          w_found       = 1'b1;
          w_load[w_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    if (!bus.enable) begin
      w_state_nxt = IDLE;
      w_gap_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = GAP;
          w_gap_nxt   = w_gap_val;
        end
        GAP: begin
          if (r_gap == 9'd0) w_state_nxt = SPAWN;
          else if (w_tick)   w_gap_nxt   = r_gap - 9'd1;
        end
        SPAWN: begin
          w_state_nxt = GAP;
          w_gap_nxt   = w_gap_val;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gap       <= '0;
      r_hit_pulse <= 1'b0;
      r_hit_cnt   <= '0;
      r_to_pulse  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap       <= w_gap_nxt;
      r_hit_pulse <= bus.enable && (|w_hit);
      r_hit_cnt   <= bus.enable ? popcnt5(w_hit) : 3'd0;
      r_to_pulse  <= bus.enable && (|w_exp);
    end
  end

  assign bus.mole_led      = w_lit;
  assign bus.active_cnt    = popcnt5(w_lit);
  assign bus.hit_pulse     = r_hit_pulse;
  assign bus.hit_count     = r_hit_cnt;
  assign bus.timeout_pulse = r_to_pulse;
endmodule
